// File: rtl/systolic_conv_scheduler_if.sv
// Scheduler bus bundle: frame control, pixel memory read port, array window/results
// and the downstream result handshake.
// The scheduler uses the master view and the surrounding environment uses the slave view.
interface systolic_conv_scheduler_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pix_rd;
  logic [AW-1:0]     pix_addr;
  logic [DW-1:0]     pix_data;
  logic [16*DW-1:0]  win_flat;
  logic              arr_rst;
  logic [DW-1:0]     arr_c11;
  logic [DW-1:0]     arr_c12;
  logic [DW-1:0]     arr_c21;
  logic [DW-1:0]     arr_c22;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_row;
  logic [7:0]        res_col;
  logic [4*DW-1:0]   res_data;

  modport master (
    input  start, pix_data, arr_c11, arr_c12, arr_c21, arr_c22, res_ready,
    output busy, done, pix_rd, pix_addr, win_flat, arr_rst,
           res_valid, res_row, res_col, res_data
  );

  modport slave (
    output start, pix_data, arr_c11, arr_c12, arr_c21, arr_c22, res_ready,
    input  busy, done, pix_rd, pix_addr, win_flat, arr_rst,
           res_valid, res_row, res_col, res_data
  );
endinterface

// File: rtl/systolic_conv_scheduler.sv
// Frame-level controller for the 3x3 systolic array.
// The image is cut into overlapping 4x4 windows with stride 2, and the windows are visited in raster order.
// For each window the controller reads 16 pixels, runs the array, and hands off the 2x2 result.
//
// state | meaning
// IDLE  | array held in reset, waiting for start
// LOAD  | k=0..16: read 16 pixels, fill window one cycle behind the read
// RUN   | array out of reset for ARRAY_LAT cycles, result captured on the last
// OUT   | result presented on res_*, waits for res_ready
module systolic_conv_scheduler #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int DW        = 8,
  parameter int AW        = 6,
  parameter int ARRAY_LAT = 24
) (
  input  logic clk,
  input  logic rst,
  systolic_conv_scheduler_if.master bus
);
  localparam int NT_R = (IMG_H - 2) / 2;
  localparam int NT_C = (IMG_W - 2) / 2;
  localparam int RCW  = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t                state, state_nxt;
  logic [4:0]            k;
  logic [3:0]            k_m1;
  logic [RCW-1:0]        run_cnt;
  logic [7:0]            tr, tc;
  logic [15:0][DW-1:0]   win;
  logic [4*DW-1:0]       res_q;
  logic [7:0]            row_q, col_q;
  logic                  done_q;
  logic                  load_end, run_end, last_col, last_tile;
  logic [AW-1:0]         addr;

  assign k_m1      = 4'(k - 5'd1);
  assign load_end  = (k == 5'd16);
  assign run_end   = (run_cnt == '0);
  assign last_col  = (tc == 8'(NT_C - 1));
  assign last_tile = last_col && (tr == 8'(NT_R - 1));
  assign addr      = (AW'(tr) * AW'(2) + AW'(k[3:2])) * AW'(IMG_W)
                   + AW'(tc) * AW'(2) + AW'(k[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; res_ready only matters in OUT, start only in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    if (load_end) state_nxt = RUN;
      RUN:     if (run_end) state_nxt = OUT;
      OUT:     if (bus.res_ready) state_nxt = last_tile ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load counter, latency down-counter, window fill, tile indices, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      run_cnt <= '0;
      tr      <= '0;
      tc      <= '0;
      win     <= '0;
      res_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == OUT) && bus.res_ready && last_tile;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tr <= '0;
            tc <= '0;
            k  <= '0;
          end
        end
        LOAD: begin
          if (k != 5'd0) win[k_m1] <= bus.pix_data;
          if (load_end) begin
            k       <= '0;
            run_cnt <= RCW'(ARRAY_LAT - 1);
          end else begin
            k <= k + 5'd1;
          end
        end
        RUN: begin
          if (run_end) begin
            res_q <= {bus.arr_c22, bus.arr_c21, bus.arr_c12, bus.arr_c11};
            row_q <= tr;
            col_q <= tc;
          end else begin
            run_cnt <= run_cnt - RCW'(1);
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            if (last_col) begin
              tc <= '0;
              tr <= last_tile ? 8'd0 : tr + 8'd1;
            end else begin
              tc <= tc + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs from the current state and the load counter
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.pix_rd    = 1'b0;
    bus.pix_addr  = '0;
    bus.arr_rst   = 1'b1;
    bus.res_valid = 1'b0;
    case (state)
      LOAD: begin
        if (!load_end) begin
          bus.pix_rd   = 1'b1;
          bus.pix_addr = addr;
        end
      end
      RUN:     bus.arr_rst = 1'b0;
      OUT:     bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.done     = done_q;
  assign bus.win_flat = win;
  assign bus.res_data = res_q;
  assign bus.res_row  = row_q;
  assign bus.res_col  = col_q;
endmodule

// File: doc/systolic_conv_scheduler.md
# systolic_conv_scheduler

Frame-level controller for `systolic_three_by_three_module`. It tiles an IMG_H×IMG_W 8-bit image, held in an external synchronous-read pixel memory, into overlapping 4×4 windows with stride 2. For each window it loads the pixels, pulses the array through reset and run, captures the 2×2 result and hands it downstream over a valid/ready port. It sits between the image buffer and the feature-map writer. The 3×3 filter is wired straight to the array and is not sequenced here.

## Interface
Parameters:
- IMG_W, 8, image width in pixels; even, ≥4
- IMG_H, 8, image height in pixels; even, ≥4
- DW, 8, pixel and result width
- AW, 6, pixel address width; ≥ clog2(IMG_W*IMG_H)
- ARRAY_LAT, 24, cycles the array is held out of reset before its outputs are valid; ≥1

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until the final result handshake
- done  out  1  one-cycle pulse after the last result is accepted
- pix_rd  out  1  pixel memory read strobe
- pix_addr  out  AW  row-major address, row*IMG_W + col
- pix_data  in  DW  read data, valid the cycle after pix_rd
- win_flat  out  16*DW  window to array in11..in44, row-major, in11 at [DW-1:0]
- arr_rst  out  1  drives the array rst input
- arr_c11, arr_c12, arr_c21, arr_c22  in  DW each  array outputs
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- res_row, res_col  out  8 each  tile indices tr, tc
- res_data  out  4*DW  {c22, c21, c12, c11}

## Operation
- Tiles:
  - NT_R = (IMG_H-2)/2 and NT_C = (IMG_W-2)/2.
  - Tile (tr,tc) has its window origin at pixel (2tr, 2tc).
  - Tiles are visited in raster order: tc inner, tr outer.
- FSM: IDLE, LOAD, RUN, OUT.
- IDLE: arr_rst=1, busy=0. On start, tr=tc=0 and the FSM goes to LOAD.
- LOAD:
  - Counter k runs 0..16.
  - For k<16: pix_rd=1 and pix_addr=(2tr+k/4)*IMG_W + 2tc + k%4.
  - For k≥1: window element k-1 is loaded from pix_data.
  - After k=16 the FSM goes to RUN. arr_rst=1 throughout LOAD.
- RUN:
  - arr_rst=0. win_flat stays stable.
  - A counter runs 0..ARRAY_LAT-1.
  - On the last count, arr_c* is registered into res_data, res_row/res_col are set to tr/tc, and the FSM goes to OUT.
- OUT:
  - arr_rst=1, res_valid=1.
  - res_data, res_row and res_col are held until res_valid && res_ready.
  - On the handshake, the tile indices advance and the FSM goes to LOAD, or to IDLE after the last tile.
  - On the IDLE transition, done is pulsed in the next cycle and busy=0 in that same cycle.
- Arithmetic:
  - Array results pass through unmodified; sums wrap mod 2^DW inside the array.
  - Tile indices wrap to 0 only at frame end, never mid-frame.
- Boundaries:
  - start while busy is ignored.
  - start and rst in the same cycle: rst wins.
  - rst in any state: the next cycle is IDLE with every output at its reset value; no done pulse; the partial frame is discarded.
  - res_ready high outside OUT is ignored.
  - pix_data is ignored when no read is pending.

## Timing
- Reset values: busy=0, done=0, pix_rd=0, pix_addr=0, win_flat=0, arr_rst=1, res_valid=0, res_row=0, res_col=0, res_data=0.
- Start accepted in cycle S: LOAD occupies S+1..S+17 and RUN occupies S+18..S+17+ARRAY_LAT.
- The first res_valid appears at S+18+ARRAY_LAT, which is S+42 at default parameters.
- Per tile with res_ready tied high: 17 + ARRAY_LAT + 1 cycles, i.e. 42 at defaults.
- Default frame (9 tiles): last handshake at S+378, done at S+379.
- Back-pressure adds one cycle per cycle that res_ready is low during OUT.
- arr_rst is low for exactly ARRAY_LAT consecutive cycles per tile.

## Test plan
- Raster order and first result:
  - Stimulus: 8×8 image with pixel(r,c) = 8r+c+1, all-ones filter, real array, res_ready=1.
  - Required: 9 results in raster order; tile (0,0) res_data c11=90, c12=99, c21=162, c22=171.
  - Required: all 9 tiles match a golden model mod 256.
- Read address sequence:
  - Tile (0,0) pix_addr must be 0-3, 8-11, 16-19, 24-27.
  - Tile (0,1) must start at address 2; tile (1,0) must start at address 16.
  - pix_rd must be high for exactly 16 cycles per tile.
- Cycle timing:
  - start at S, res_ready=1 → res_valid at S+42 and every 42 cycles after.
  - done high only at S+379; busy falls at S+379.
- Back-pressure:
  - Hold res_ready low for 10 cycles while tile 4 is in OUT.
  - Required: res_valid, res_data and res_row/res_col stay stable; pix_rd=0 and arr_rst=1 during the stall.
  - Required: done moves to S+389.
- Reset mid-operation:
  - Assert rst for 1 cycle during tile 2 RUN.
  - Required: next cycle IDLE, arr_rst=1, res_valid=0, busy=0, and no done pulse.
  - Required: a new start produces a full 9-tile frame identical to the first scenario.
- Start filtering:
  - start pulses during LOAD and OUT are ignored; the frame completes normally.
  - start and rst asserted together leave the block in IDLE.
